cby_param_shadow: RTL and testbench

CBY_PARAM_SHADOW -- requirements
Module: cby_param_shadow

---
 rtl/cby_param_shadow.sv | 127 ++++++++++++
 tb/tb_cby_param_shadow.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cby_param_shadow.sv
// Vertical connection block with a shadowed configuration chain.
// Bits shift serially into a chain. The chain contents move into the active
// register only when a load ends with exactly the expected bit count, so the
// ipin muxes never see a partially shifted configuration.
module cby_param_shadow #(
   parameter int unsigned CHAN_WIDTH = 12,
   parameter int unsigned NUM_IPIN   = 2,
   parameter int unsigned MUX_SIZE   = 8
) (
   input  logic                  prog_clk,
   input  logic                  pReset,
   input  logic                  config_enable,
   input  logic                  ccff_head,
   input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
   input  logic [CHAN_WIDTH-1:0] chany_top_in,
   output logic [CHAN_WIDTH-1:0] chany_top_out,
   output logic [CHAN_WIDTH-1:0] chany_bottom_out,
   output logic [NUM_IPIN-1:0]   ipin_out,
   output logic                  ccff_tail,
   output logic                  cfg_loaded,
   output logic                  cfg_error
);

   localparam int unsigned SEL_BITS = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
   localparam int unsigned L        = NUM_IPIN * SEL_BITS;
   localparam int unsigned CNT_W    = $clog2(L + 2);
   localparam int unsigned MUX_PAD  = 1 << SEL_BITS;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(L + 1);

   logic [L-1:0]     chain_q,  chain_d;
   logic [L-1:0]     active_q, active_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             en_q,     en_d;
   logic             loaded_q, loaded_d;
   logic             err_q,    err_d;

   logic             rise;
   logic             fall;

   assign rise = config_enable & ~en_q;
   assign fall = en_q & ~config_enable;

   // Next-state: chain shift, saturating bit count, commit or flag error on enable drop.
   always_comb begin
      chain_d  = chain_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      en_d     = config_enable;
      loaded_d = loaded_q;
      err_d    = err_q;

      if (config_enable) begin
         chain_d    = chain_q << 1;
         chain_d[0] = ccff_head;
         // The edge that starts a load is itself a shift, so the count
         // restarts at 1 rather than 0.
         if (rise) begin
            cnt_d = CNT_W'(1);
            err_d = 1'b0;
         end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (fall) begin
         if (cnt_q == CNT_FULL) begin
            active_d = chain_q;
            loaded_d = 1'b1;
            err_d    = 1'b0;
         end else begin
            err_d    = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         chain_q  <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         chain_q  <= chain_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
      end
   end

   assign chany_top_out    = chany_bottom_in;
   assign chany_bottom_out = chany_top_in;
   assign ccff_tail        = chain_q[L-1];
   assign cfg_loaded       = loaded_q;
   assign cfg_error        = err_q;

   // The mux input vector is padded to a power of two with zeros, so a
   // select at or above MUX_SIZE yields 0 without a separate range check.
   for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
      logic [MUX_PAD-1:0]  mux_in;
      logic [SEL_BITS-1:0] sel;

      assign sel = active_q[gi*SEL_BITS +: SEL_BITS];

      for (genvar gj = 0; gj < MUX_PAD; gj++) begin : g_in
         if (gj < MUX_SIZE) begin : g_used
            localparam int unsigned T = (gi * MUX_SIZE / 2 + gj / 2) % CHAN_WIDTH;
            if (gj % 2 == 0) begin : g_bot
               assign mux_in[gj] = chany_bottom_in[T];
            end else begin : g_top
               assign mux_in[gj] = chany_top_in[T];
            end
         end else begin : g_pad
            assign mux_in[gj] = 1'b0;
         end
      end

      assign ipin_out[gi] = loaded_q & mux_in[sel];
   end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Bench for cby_param_shadow: default instance plus a MUX_SIZE=6 instance.
// A driver feeds both instances and pushes expected outputs into a queue.
// A monitor pops one entry at each falling clock edge and compares it.
module tb_cby_param_shadow;

   localparam int W = 12;
   localparam int N = 2;
   localparam int S = 3;
   localparam int L = N * S;

   logic         prog_clk = 1'b0;
   logic         pReset;
   logic         config_enable;
   logic         ccff_head;
   logic [W-1:0] bot_in, top_in;
   logic [W-1:0] top_out8, bot_out8, top_out6, bot_out6;
   logic [N-1:0] ipin8, ipin6;
   logic         tail8, tail6, ld8, ld6, err8, err6;

   always #5 prog_clk = ~prog_clk;

   cby_param_shadow u_dut8 (
      .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
      .ccff_head(ccff_head), .chany_bottom_in(bot_in), .chany_top_in(top_in),
      .chany_top_out(top_out8), .chany_bottom_out(bot_out8), .ipin_out(ipin8),
      .ccff_tail(tail8), .cfg_loaded(ld8), .cfg_error(err8)
   );

   cby_param_shadow #(.CHAN_WIDTH(12), .NUM_IPIN(2), .MUX_SIZE(6)) u_dut6 (
      .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
      .ccff_head(ccff_head), .chany_bottom_in(bot_in), .chany_top_in(top_in),
      .chany_top_out(top_out6), .chany_bottom_out(bot_out6), .ipin_out(ipin6),
      .ccff_tail(tail6), .cfg_loaded(ld6), .cfg_error(err6)
   );

   typedef struct {
      logic [W-1:0] top_out;
      logic [W-1:0] bot_out;
      logic [N-1:0] ipin8;
      logic [N-1:0] ipin6;
      logic         tail;
      logic         loaded;
      logic         err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   rand_tracks = 0;

   // Reference model: last L shifted bits, length of current load, committed selects.
   bit hist[$];
   int cur_n;
   bit en_prev, m_loaded, m_err;
   int m_sel[N];

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < L; k++) hist.push_back(1'b0);
      cur_n    = 0;
      en_prev  = 0;
      m_loaded = 0;
      m_err    = 0;
      for (int i = 0; i < N; i++) m_sel[i] = 0;
   endtask

   // hist holds the last L bits in shift order; the last ipin's group is shifted first,
   // and within a group the earliest bit is the most significant.
   function automatic int group_value(int i);
      int v = 0;
      for (int n = 0; n < S; n++) v = v * 2 + int'(hist[(N - 1 - i) * S + n]);
      return v;
   endfunction

   task automatic model_edge(bit en, bit head);
      if (en) begin
         if (!en_prev) begin
            cur_n = 0;
            m_err = 0;
         end
         hist.push_back(head);
         void'(hist.pop_front());
         cur_n++;
      end else if (en_prev) begin
         if (cur_n == L) begin
            for (int i = 0; i < N; i++) m_sel[i] = group_value(i);
            m_loaded = 1;
            m_err    = 0;
         end else begin
            m_err = 1;
         end
      end
      en_prev = en;
   endtask

   function automatic bit exp_pin(int m, int i, int s);
      int t;
      if (!m_loaded || s >= m) return 1'b0;
      t = (i * m / 2 + s / 2) % W;
      return (s % 2 == 0) ? bot_in[t] : top_in[t];
   endfunction

   function automatic exp_t expect_now();
      exp_t x;
      x.top_out = bot_in;
      x.bot_out = top_in;
      for (int i = 0; i < N; i++) begin
         x.ipin8[i] = exp_pin(8, i, m_sel[i]);
         x.ipin6[i] = exp_pin(6, i, m_sel[i]);
      end
      x.tail   = hist[0];
      x.loaded = m_loaded;
      x.err    = m_err;
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: compare the DUT outputs against the oldest expectation.
   always @(negedge prog_clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("top_out8",  32'(top_out8), 32'(e.top_out));
         chk("bot_out8",  32'(bot_out8), 32'(e.bot_out));
         chk("top_out6",  32'(top_out6), 32'(e.top_out));
         chk("bot_out6",  32'(bot_out6), 32'(e.bot_out));
         chk("ipin8",     32'(ipin8),    32'(e.ipin8));
         chk("ipin6",     32'(ipin6),    32'(e.ipin6));
         chk("tail8",     32'(tail8),    32'(e.tail));
         chk("tail6",     32'(tail6),    32'(e.tail));
         chk("loaded8",   32'(ld8),      32'(e.loaded));
         chk("loaded6",   32'(ld6),      32'(e.loaded));
         chk("error8",    32'(err8),     32'(e.err));
         chk("error6",    32'(err6),     32'(e.err));
      end
   end

   task automatic cycle(bit en, bit head);
      if (rand_tracks) begin
         bot_in = W'($urandom);
         top_in = W'($urandom);
      end
      config_enable = en;
      ccff_head     = head;
      @(posedge prog_clk);
      if (!pReset) model_reset();
      else model_edge(en, head);
      #1 sb.push_back(expect_now());
      @(negedge prog_clk);
      #1;
   endtask

   // Shift bits[0] first, then drop enable and idle.
   task automatic load(int n, logic [31:0] bits);
      for (int k = 0; k < n; k++) cycle(1'b1, bits[k]);
      cycle(1'b0, 1'($urandom));
      repeat (2) cycle(1'b0, 1'b0);
   endtask

   // Reset asserted shortly after a shift edge; outputs are checked before the next edge.
   task automatic reset_mid(bit en, bit head);
      config_enable = en;
      ccff_head     = head;
      @(posedge prog_clk);
      #2 pReset = 1'b0;
      model_reset();
      sb.push_back(expect_now());
      @(negedge prog_clk);
      #1;
   endtask

   initial begin
      pReset        = 1'b0;
      config_enable = 1'b0;
      ccff_head     = 1'b0;
      bot_in        = 12'hFFF;
      top_in        = 12'h000;
      model_reset();
      #1;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      pReset = 1'b1;
      repeat (3) cycle(1'b0, 1'b0);

      // Bits 1,0,1,0,1,1: ipin0 select 3, ipin1 select 5.
      bot_in = 12'h000;
      top_in = 12'h042;
      load(6, 32'b110101);
      // Under-shift, then over-shift past saturation.
      load(5, $urandom);
      load(9, $urandom);
      load(14, $urandom);

      // ipin1 select 2, ipin0 select 7 (out of range for MUX_SIZE=6).
      rand_tracks = 1;
      load(6, 32'b111010);

      // Reset in the middle of a shift, then a full reload.
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      reset_mid(1'b1, 1'b1);
      cycle(1'b1, 1'b0);
      pReset = 1'b1;
      load(6, $urandom);

      for (int it = 0; it < 40; it++) begin
         int n;
         n = ($urandom_range(9) < 7) ? L : int'($urandom_range(L + 3, 1));
         if ($urandom_range(9) == 0) begin
            for (int k = 0; k < int'($urandom_range(L - 1, 1)); k++)
               cycle(1'b1, 1'($urandom));
            reset_mid(1'b1, 1'($urandom));
            cycle(1'b0, 1'b0);
            pReset = 1'b1;
         end
         load(n, $urandom);
      end

      for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge prog_clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
